// File: rtl/rob_commit_ctrl_pkg.sv
// ============================================================================
// rob_commit_ctrl_pkg : shared widths and encodings for the ROB commit sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package rob_commit_ctrl_pkg;

  localparam int          DATA_LEN      = 32;
  localparam int          REG_ADDR_LEN  = 5;
  localparam int          ROB_ADDR_LEN  = 4;
  localparam logic [4:0]  ZERO_REG_ADDR = 5'd0;

  // Encoding 3 is reserved and retires like a plain register write.
  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_RSVD   = 2'd3
  } head_type_e;

  typedef enum logic [1:0] {
    CMT_RUN     = 2'd0,
    CMT_WAIT_ST = 2'd1,
    CMT_FLUSH   = 2'd2
  } cmt_state_e;

endpackage : rob_commit_ctrl_pkg

`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
// ============================================================================
// rob_commit_ctrl : in-order retirement of the ROB head into the register file,
// store commit handshake and mispredict flush generation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int ROB_W = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              head_valid,
  input  logic [1:0]        head_type,
  input  logic              head_writes_rd,
  input  logic [4:0]        head_dest,
  input  logic [31:0]       head_data,
  input  logic [ROB_W-1:0]  head_rob_num,
  input  logic              head_mispredict,
  input  logic [31:0]       head_target_pc,
  output logic              head_pop,
  output logic              has_from_rob,
  output logic [4:0]        dest_reg_num,
  output logic [31:0]       in_reg_data,
  output logic [ROB_W-1:0]  in_reg_rob_num,
  output logic              st_commit_valid,
  output logic [ROB_W-1:0]  st_commit_rob_num,
  input  logic              st_done,
  output logic              has_misbranch,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  retired_cnt
);

  cmt_state_e        state_q, state_d;
  logic              st_commit_valid_q, st_commit_valid_d;
  logic [ROB_W-1:0]  st_commit_rob_num_q, st_commit_rob_num_d;
  logic              has_misbranch_q, has_misbranch_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
  logic              pop_from_run;

  always_comb begin
    state_d             = state_q;
    st_commit_valid_d   = st_commit_valid_q;
    st_commit_rob_num_d = st_commit_rob_num_q;
    has_misbranch_d     = has_misbranch_q;
    redirect_pc_d       = redirect_pc_q;
    head_pop            = 1'b0;
    pop_from_run        = 1'b0;

    // With rdy low nothing advances; a pending flush simply stays asserted.
    if (rdy) begin
      unique case (state_q)
        CMT_RUN: begin
          if (head_valid) begin
            if (head_type == TYPE_STORE) begin
              st_commit_valid_d   = 1'b1;
              st_commit_rob_num_d = head_rob_num;
              state_d             = CMT_WAIT_ST;
            end else begin
              head_pop     = 1'b1;
              pop_from_run = 1'b1;
              if (head_type == TYPE_BRANCH && head_mispredict) begin
                has_misbranch_d = 1'b1;
                redirect_pc_d   = head_target_pc;
                state_d         = CMT_FLUSH;
              end
            end
          end
        end
        CMT_WAIT_ST: begin
          if (st_done) begin
            head_pop            = 1'b1;
            st_commit_valid_d   = 1'b0;
            st_commit_rob_num_d = '0;
            state_d             = CMT_RUN;
          end
        end
        CMT_FLUSH: begin
          has_misbranch_d = 1'b0;
          redirect_pc_d   = 32'd0;
          state_d         = CMT_RUN;
        end
        default: state_d = CMT_RUN;
      endcase
    end

    retired_cnt_d = head_pop ? retired_cnt_q + CNT_W'(1) : retired_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= CMT_RUN;
      st_commit_valid_q   <= 1'b0;
      st_commit_rob_num_q <= '0;
      has_misbranch_q     <= 1'b0;
      redirect_pc_q       <= 32'd0;
      retired_cnt_q       <= '0;
    end else begin
      state_q             <= state_d;
      st_commit_valid_q   <= st_commit_valid_d;
      st_commit_rob_num_q <= st_commit_rob_num_d;
      has_misbranch_q     <= has_misbranch_d;
      redirect_pc_q       <= redirect_pc_d;
      retired_cnt_q       <= retired_cnt_d;
    end
  end

  // Stores retire without a register write, so only RUN-state pops drive the port.
  assign has_from_rob   = pop_from_run && head_writes_rd && (head_dest != ZERO_REG_ADDR);
  assign dest_reg_num   = pop_from_run ? head_dest    : 5'd0;
  assign in_reg_data    = pop_from_run ? head_data    : 32'd0;
  assign in_reg_rob_num = pop_from_run ? head_rob_num : '0;

  assign st_commit_valid   = st_commit_valid_q;
  assign st_commit_rob_num = st_commit_rob_num_q;
  assign has_misbranch     = has_misbranch_q;
  assign redirect_pc       = redirect_pc_q;
  assign retired_cnt       = retired_cnt_q;

endmodule : rob_commit_ctrl

`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
// ============================================================================
// tb_rob_commit_ctrl : directed self-checking bench for rob_commit_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_ctrl;

  localparam int ROB_W = 4;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              head_valid;
  logic [1:0]        head_type;
  logic              head_writes_rd;
  logic [4:0]        head_dest;
  logic [31:0]       head_data;
  logic [ROB_W-1:0]  head_rob_num;
  logic              head_mispredict;
  logic [31:0]       head_target_pc;
  logic              head_pop;
  logic              has_from_rob;
  logic [4:0]        dest_reg_num;
  logic [31:0]       in_reg_data;
  logic [ROB_W-1:0]  in_reg_rob_num;
  logic              st_commit_valid;
  logic [ROB_W-1:0]  st_commit_rob_num;
  logic              st_done;
  logic              has_misbranch;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  retired_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rob_commit_ctrl #(.ROB_W(ROB_W), .CNT_W(CNT_W)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .head_valid        (head_valid),
    .head_type         (head_type),
    .head_writes_rd    (head_writes_rd),
    .head_dest         (head_dest),
    .head_data         (head_data),
    .head_rob_num      (head_rob_num),
    .head_mispredict   (head_mispredict),
    .head_target_pc    (head_target_pc),
    .head_pop          (head_pop),
    .has_from_rob      (has_from_rob),
    .dest_reg_num      (dest_reg_num),
    .in_reg_data       (in_reg_data),
    .in_reg_rob_num    (in_reg_rob_num),
    .st_commit_valid   (st_commit_valid),
    .st_commit_rob_num (st_commit_rob_num),
    .st_done           (st_done),
    .has_misbranch     (has_misbranch),
    .redirect_pc       (redirect_pc),
    .retired_cnt       (retired_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic v, input logic [1:0] t, input logic wr,
                          input logic [4:0] d, input logic [31:0] data,
                          input logic [3:0] rob, input logic mis, input logic [31:0] pc);
    head_valid      = v;
    head_type       = t;
    head_writes_rd  = wr;
    head_dest       = d;
    head_data       = data;
    head_rob_num    = rob;
    head_mispredict = mis;
    head_target_pc  = pc;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; st_done = 1'b0;
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pop",     {31'd0, head_pop},        32'd0);
    chk("rst_scv",     {31'd0, st_commit_valid}, 32'd0);
    chk("rst_misb",    {31'd0, has_misbranch},   32'd0);
    chk("rst_redir",   redirect_pc,              32'd0);
    chk("rst_cnt",     retired_cnt,              32'd0);
    tick();

    // REG writes: x5 then x0
    set_head(1'b1, 2'd0, 1'b1, 5'd5, 32'h11, 4'd3, 1'b0, 32'd0);
    @(negedge clk);
    chk("x5_pop",  {31'd0, head_pop},     32'd1);
    chk("x5_we",   {31'd0, has_from_rob}, 32'd1);
    chk("x5_dest", {27'd0, dest_reg_num}, 32'd5);
    chk("x5_data", in_reg_data,           32'h11);
    chk("x5_tag",  {28'd0, in_reg_rob_num}, 32'd3);
    tick();
    set_head(1'b1, 2'd0, 1'b1, 5'd0, 32'h22, 4'd4, 1'b0, 32'd0);
    @(negedge clk);
    chk("x0_pop", {31'd0, head_pop},     32'd1);
    chk("x0_we",  {31'd0, has_from_rob}, 32'd0);
    tick();
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    chk("reg_cnt", retired_cnt, 32'd2);

    // Store handshake, st_done three cycles after presentation
    set_head(1'b1, 2'd1, 1'b0, 5'd0, 32'd0, 4'd7, 1'b0, 32'd0);
    @(negedge clk);
    chk("st_pop0", {31'd0, head_pop}, 32'd0);
    tick();
    chk("st_scv",  {31'd0, st_commit_valid},   32'd1);
    chk("st_tag",  {28'd0, st_commit_rob_num}, 32'd7);
    @(negedge clk);
    chk("st_pop1", {31'd0, head_pop}, 32'd0);
    tick();
    @(negedge clk);
    chk("st_pop2", {31'd0, head_pop}, 32'd0);
    tick();
    st_done = 1'b1;
    @(negedge clk);
    chk("st_pop3", {31'd0, head_pop},     32'd1);
    chk("st_we",   {31'd0, has_from_rob}, 32'd0);
    tick();
    st_done = 1'b0;
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    chk("st_scv_off", {31'd0, st_commit_valid}, 32'd0);
    chk("st_cnt",     retired_cnt,              32'd3);

    // Mispredicted branch writing x1
    set_head(1'b1, 2'd2, 1'b1, 5'd1, 32'h2004, 4'd5, 1'b1, 32'h1000);
    @(negedge clk);
    chk("br_pop",  {31'd0, head_pop},     32'd1);
    chk("br_we",   {31'd0, has_from_rob}, 32'd1);
    chk("br_dest", {27'd0, dest_reg_num}, 32'd1);
    chk("br_data", in_reg_data,           32'h2004);
    tick();
    chk("br_misb",  {31'd0, has_misbranch}, 32'd1);
    chk("br_redir", redirect_pc,            32'h1000);
    chk("br_cnt",   retired_cnt,            32'd4);
    @(negedge clk);
    chk("fl_pop", {31'd0, head_pop},     32'd0);
    chk("fl_we",  {31'd0, has_from_rob}, 32'd0);
    tick();
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    chk("fl_misb_off", {31'd0, has_misbranch}, 32'd0);
    chk("fl_cnt",      retired_cnt,            32'd4);

    // rdy stall in WAIT_ST while st_done pulses
    set_head(1'b1, 2'd1, 1'b0, 5'd0, 32'd0, 4'd9, 1'b0, 32'd0);
    tick();
    rdy = 1'b0; st_done = 1'b1;
    @(negedge clk);
    chk("stall_st_pop", {31'd0, head_pop}, 32'd0);
    tick();
    chk("stall_st_scv", {31'd0, st_commit_valid},   32'd1);
    chk("stall_st_tag", {28'd0, st_commit_rob_num}, 32'd9);
    chk("stall_st_cnt", retired_cnt,                32'd4);
    rdy = 1'b1;
    @(negedge clk);
    chk("stall_st_pop2", {31'd0, head_pop}, 32'd1);
    tick();
    st_done = 1'b0;
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    chk("stall_st_scv_off", {31'd0, st_commit_valid}, 32'd0);
    chk("stall_st_cnt2",    retired_cnt,              32'd5);

    // rdy stall in FLUSH; branch writing x0 must not strobe the register file
    set_head(1'b1, 2'd2, 1'b1, 5'd0, 32'h55, 4'd2, 1'b1, 32'h2000);
    @(negedge clk);
    chk("br2_pop", {31'd0, head_pop},     32'd1);
    chk("br2_we",  {31'd0, has_from_rob}, 32'd0);
    tick();
    rdy = 1'b0;
    set_head(1'b1, 2'd0, 1'b1, 5'd3, 32'h66, 4'd6, 1'b0, 32'd0);
    @(negedge clk);
    chk("stall_fl_pop", {31'd0, head_pop}, 32'd0);
    tick();
    tick();
    chk("stall_fl_misb",  {31'd0, has_misbranch}, 32'd1);
    chk("stall_fl_redir", redirect_pc,            32'h2000);
    rdy = 1'b1;
    @(negedge clk);
    chk("fl2_pop", {31'd0, head_pop}, 32'd0);
    tick();
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    chk("fl2_misb_off", {31'd0, has_misbranch}, 32'd0);
    chk("fl2_cnt",      retired_cnt,            32'd6);

    // Reset while waiting on a store
    set_head(1'b1, 2'd1, 1'b0, 5'd0, 32'd0, 4'd11, 1'b0, 32'd0);
    tick();
    chk("rs_scv_pre", {31'd0, st_commit_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_scv",  {31'd0, st_commit_valid},   32'd0);
    chk("rs_tag",  {28'd0, st_commit_rob_num}, 32'd0);
    chk("rs_misb", {31'd0, has_misbranch},     32'd0);
    chk("rs_cnt",  retired_cnt,                32'd0);
    set_head(1'b1, 2'd0, 1'b1, 5'd7, 32'h33, 4'd1, 1'b0, 32'd0);
    @(negedge clk);
    chk("rs_pop",  {31'd0, head_pop},     32'd1);
    chk("rs_we",   {31'd0, has_from_rob}, 32'd1);
    chk("rs_dest", {27'd0, dest_reg_num}, 32'd7);
    tick();
    set_head(1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    chk("rs_cnt2", retired_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rob_commit_ctrl

`default_nettype wire
